// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared constants and state encoding for the memory access sequencer
package mem_access_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int MEM_DEPTH  = 2 ** DEF_ADDR_W;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wait_cnt.sv
// rtl/mem_wait_cnt.sv - wait-state down counter, done when the current access cycle is the last one
module mem_wait_cnt #(
    parameter int WAIT_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    logic [CNT_W-1:0] cnt;

    // Load WAIT_CYC-1 when an access starts, then count down once per held cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(WAIT_CYC - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - request/response sequencer driving an 8x16 memory with wait states and wrapping read bursts
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [ADDR_W-1:0] ReqLen,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic [ADDR_W-1:0] RspAddr,
    output logic              RspLast,
    output logic              Busy,
    output logic              enable,
    output logic              ReadWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] DataIn,
    input  logic [DATA_W-1:0] DataOut
);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   remaining, remaining_d;
    logic                req_ready_d, rsp_valid_d, rsp_last_d, busy_d;
    logic                enable_d, read_write_d;
    logic [DATA_W-1:0]   rsp_data_d, data_in_d;
    logic [ADDR_W-1:0]   rsp_addr_d, address_d;
    logic                wait_load, wait_dec, wait_done;

    mem_wait_cnt #(
        .WAIT_CYC (WAIT_CYC)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (wait_load),
        .dec   (wait_dec),
        .done  (wait_done)
    );

    // Register every output together with the FSM state so the memory sees glitch-free controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            ReqReady  <= 1'b0;
            RspValid  <= 1'b0;
            RspData   <= '0;
            RspAddr   <= '0;
            RspLast   <= 1'b0;
            Busy      <= 1'b0;
            enable    <= 1'b0;
            ReadWrite <= RW_READ;
            Address   <= '0;
            DataIn    <= '0;
        end else begin
            state     <= state_d;
            remaining <= remaining_d;
            ReqReady  <= req_ready_d;
            RspValid  <= rsp_valid_d;
            RspData   <= rsp_data_d;
            RspAddr   <= rsp_addr_d;
            RspLast   <= rsp_last_d;
            Busy      <= busy_d;
            enable    <= enable_d;
            ReadWrite <= read_write_d;
            Address   <= address_d;
            DataIn    <= data_in_d;
        end
    end

    // Next-state and next-output decode; Address/DataIn only move on cycles where enable is low
    always_comb begin
        state_d      = state;
        remaining_d  = remaining;
        req_ready_d  = ReqReady;
        rsp_valid_d  = RspValid;
        rsp_data_d   = RspData;
        rsp_addr_d   = RspAddr;
        rsp_last_d   = RspLast;
        enable_d     = enable;
        read_write_d = ReadWrite;
        address_d    = Address;
        data_in_d    = DataIn;
        wait_load    = 1'b0;
        wait_dec     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (ReqValid && ReqReady) begin
                    req_ready_d  = 1'b0;
                    state_d      = ST_ACCESS;
                    enable_d     = 1'b1;
                    read_write_d = ~ReqWrite;
                    address_d    = ReqAddr;
                    remaining_d  = ReqLen;
                    wait_load    = 1'b1;
                    if (ReqWrite) begin
                        data_in_d = ReqData;
                    end
                end
            end
            ST_ACCESS: begin
                if (wait_done) begin
                    enable_d = 1'b0;
                    if (ReadWrite == RW_WRITE) begin
                        state_d     = ST_IDLE;
                        req_ready_d = 1'b1;
                    end else begin
                        rsp_data_d  = DataOut;
                        rsp_addr_d  = Address;
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = (remaining == '0);
                        state_d     = ST_RESP;
                    end
                end else begin
                    wait_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (RspValid && RspReady) begin
                    rsp_valid_d = 1'b0;
                    if (RspLast) begin
                        state_d     = ST_IDLE;
                        req_ready_d = 1'b1;
                    end else begin
                        address_d   = Address + ADDR_W'(1);
                        remaining_d = remaining - ADDR_W'(1);
                        enable_d    = 1'b1;
                        wait_load   = 1'b1;
                        state_d     = ST_ACCESS;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with an 8x16 memory model
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReqValid, ReqReady, ReqWrite;
    logic [2:0]  ReqAddr, ReqLen;
    logic [15:0] ReqData;
    logic        RspValid, RspReady, RspLast, Busy;
    logic [15:0] RspData;
    logic [2:0]  RspAddr;
    logic        enable, ReadWrite;
    logic [2:0]  Address;
    logic [15:0] DataIn, DataOut;

    logic [15:0] mem [8];
    logic [15:0] ref_mem [8];
    logic        preload;
    int          errors = 0;
    int          checks = 0;
    int          acc_cnt = 0;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [2:0]  len;
        logic [15:0] data;
        logic [15:0] exp_first;
        int          exp_words;
    } vec_t;

    vec_t vecs [6];

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(3), .WAIT_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqLen(ReqLen), .ReqData(ReqData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
        .RspAddr(RspAddr), .RspLast(RspLast), .Busy(Busy),
        .enable(enable), .ReadWrite(ReadWrite), .Address(Address),
        .DataIn(DataIn), .DataOut(DataOut)
    );

    always #5 clk = ~clk;

    // Memory: asynchronous read while enabled for reads, synchronous write
    assign DataOut = (enable && ReadWrite) ? mem[Address] : 16'h0000;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'hA0A0 + 16'(i);
        end else if (enable && !ReadWrite) begin
            mem[Address] <= DataIn;
        end
    end

    always @(posedge clk) begin
        if (ReqValid && ReqReady) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input bit wr, input logic [2:0] a, input logic [2:0] l, input logic [15:0] d);
        int cyc = 0;
        @(negedge clk);
        while (!ReqReady && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_wait", ReqReady, 1);
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqAddr  = a;
        ReqLen   = l;
        ReqData  = d;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        ReqAddr  = 3'($urandom);
        ReqLen   = 3'($urandom);
        ReqData  = 16'($urandom);
        ReqWrite = 1'($urandom);
        if (wr) ref_mem[a] = d;
    endtask

    // Consume a burst; every visible word is checked against the reference memory
    task automatic collect(input logic [2:0] a, input int len, input bit bp, input int stall,
                           output logic [15:0] first, output int words);
        int cyc = 0;
        int stalled = 0;
        logic [2:0] ea;
        words = 0;
        first = 16'h0;
        while (words <= len && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (words == 0 && stalled < stall && RspValid) begin
                RspReady = 1'b0;
                stalled++;
            end else if (bp) begin
                RspReady = 1'($urandom_range(0, 1));
            end else begin
                RspReady = 1'b1;
            end
            if (RspValid) begin
                ea = a + 3'(words);
                chk("rsp_addr", RspAddr, ea);
                chk("rsp_data", RspData, ref_mem[ea]);
                chk("rsp_last", RspLast, (words == len));
                chk("enable_in_resp", enable, 0);
                chk("req_ready_busy", ReqReady, 0);
                if (words == 0) first = RspData;
                if (RspReady) words++;
            end
        end
        chk("burst_done", (words == len + 1), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] first;
        int          words;
        int          n;
        int          cyc;
        int          acc0;

        for (int i = 0; i < 8; i++) ref_mem[i] = 16'hA0A0 + 16'(i);
        vecs[0] = '{0, 3'd5, 3'd0, 16'h0000, 16'hBEEF, 1};
        vecs[1] = '{0, 3'd6, 3'd3, 16'h0000, 16'hA0A6, 4};
        vecs[2] = '{0, 3'd0, 3'd7, 16'h0000, 16'hA0A0, 8};
        vecs[3] = '{1, 3'd7, 3'd0, 16'h1234, 16'h0000, 0};
        vecs[4] = '{0, 3'd7, 3'd1, 16'h0000, 16'h1234, 2};
        vecs[5] = '{0, 3'd3, 3'd0, 16'h0000, 16'hA0A3, 1};

        rst_n = 1'b0; preload = 1'b1;
        ReqValid = 0; ReqWrite = 0; ReqAddr = 0; ReqLen = 0; ReqData = 0; RspReady = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", ReqReady, 0);
        chk("rst_rsp_valid", RspValid, 0);
        chk("rst_rsp_data", RspData, 0);
        chk("rst_rsp_addr", RspAddr, 0);
        chk("rst_rsp_last", RspLast, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_enable", enable, 0);
        chk("rst_read_write", ReadWrite, 1);
        chk("rst_address", Address, 0);
        chk("rst_data_in", DataIn, 0);
        preload = 1'b0;
        rst_n = 1'b1;
        chk("rel_req_ready_pre", ReqReady, 0);
        @(posedge clk); #1;
        chk("rel_req_ready_post", ReqReady, 1);

        // Single read of address 3: one access cycle, response the cycle after
        RspReady = 1'b1;
        issue(0, 3'd3, 3'd0, 16'h0);
        @(negedge clk);
        chk("t1_enable", enable, 1);
        chk("t1_rw", ReadWrite, 1);
        chk("t1_address", Address, 3);
        chk("t1_rsp_valid_early", RspValid, 0);
        chk("t1_busy", Busy, 1);
        @(negedge clk);
        chk("t1_enable_off", enable, 0);
        chk("t1_rsp_valid", RspValid, 1);
        chk("t1_rsp_data", RspData, 16'hA0A3);
        chk("t1_rsp_addr", RspAddr, 3);
        chk("t1_rsp_last", RspLast, 1);
        @(negedge clk);
        chk("t1_rsp_valid_done", RspValid, 0);
        chk("t1_req_ready", ReqReady, 1);
        chk("t1_busy_done", Busy, 0);

        // Write BEEF to address 5: enable for exactly one cycle in write direction
        issue(1, 3'd5, 3'd0, 16'hBEEF);
        @(negedge clk);
        chk("t2_enable", enable, 1);
        chk("t2_rw", ReadWrite, 0);
        chk("t2_address", Address, 5);
        chk("t2_data_in", DataIn, 16'hBEEF);
        chk("t2_req_ready", ReqReady, 0);
        @(negedge clk);
        chk("t2_enable_off", enable, 0);
        chk("t2_req_ready_back", ReqReady, 1);
        chk("t2_busy", Busy, 0);

        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].data);
            if (!vecs[v].wr) begin
                collect(vecs[v].addr, int'(vecs[v].len), 0, 0, first, words);
                chk($sformatf("vec%0d_first", v), first, vecs[v].exp_first);
                chk($sformatf("vec%0d_words", v), words, vecs[v].exp_words);
            end
        end

        // Backpressure on word 0 for five cycles
        issue(0, 3'd2, 3'd2, 16'h0);
        collect(3'd2, 2, 0, 5, first, words);
        chk("stall_first", first, ref_mem[2]);
        chk("stall_words", words, 3);

        // ReqValid held through a burst is taken once per idle window
        RspReady = 1'b1;
        @(negedge clk);
        acc0 = acc_cnt;
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 3'd4; ReqLen = 3'd2;
        @(posedge clk); #1;
        collect(3'd4, 2, 0, 0, first, words);
        chk("hold_req_ready", ReqReady, 1);
        @(posedge clk); #1;
        ReqValid = 1'b0;
        collect(3'd4, 2, 0, 0, first, words);
        chk("hold_accepts", acc_cnt - acc0, 2);

        // Random traffic against the reference memory
        for (int t = 0; t < 40; t++) begin
            bit          wr;
            logic [2:0]  a, l;
            logic [15:0] d;
            wr = 1'($urandom_range(0, 2) == 0);
            a  = 3'($urandom);
            l  = 3'($urandom);
            d  = 16'($urandom);
            issue(wr, a, l, d);
            if (!wr) collect(a, int'(l), 1, 0, first, words);
        end

        // Reset in the middle of a burst
        RspReady = 1'b1;
        issue(0, 3'd0, 3'd3, 16'h0);
        n = 0; cyc = 0;
        while (n < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (RspValid) n++;
        end
        chk("mid_words", n, 2);
        @(posedge clk); #1;
        chk("mid_enable_before", enable, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_enable", enable, 0);
        chk("mid_rsp_valid", RspValid, 0);
        chk("mid_req_ready", ReqReady, 0);
        chk("mid_busy", Busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_hold_rsp_valid", RspValid, 0);
        end
        rst_n = 1'b1;
        chk("mid_rel_req_ready_pre", ReqReady, 0);
        @(posedge clk); #1;
        chk("mid_rel_req_ready", ReqReady, 1);
        chk("mid_rel_rsp_valid", RspValid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
